// File: rtl/compute_result_accumulator.sv
// compute_result_accumulator: per-lane saturating accumulation of the packed
// three-lane result stream, one packed RAM write per completed group.
//   clk, reset           : clock, synchronous active-high reset
//   start, len, groups,
//   base_addr            : command strobe and parameters (sampled in IDLE)
//   in_valid, in_data    : 27-bit result stream, lane k in [9k+8:9k]
//   in_ready             : high while accumulating
//   wr_en, wr_addr,
//   wr_data, wr_ready    : RAM write request held until accepted
//   busy, done, ovf      : status, end-of-command pulse, sticky saturation
module compute_result_accumulator #(
  parameter int ACC_W  = 12,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            len,
  input  logic [7:0]            groups,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  in_valid,
  input  logic [26:0]           in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [3*ACC_W-1:0]    wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;
  state_t              state_q;
  logic [7:0]          len_q, groups_q, gcnt_q, ecnt_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ACC_W-1:0]    acc_q [3];
  logic [ACC_W-1:0]    acc_d [3];
  logic [ACC_W:0]      sum_d [3];
  logic [2:0]          sat_d;
  logic                ovf_q;
  // One extra bit of headroom per lane: its carry flags saturation.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sum_d[k] = {1'b0, acc_q[k]} + (ACC_W+1)'(in_data[9*k +: 9]);
      sat_d[k] = sum_d[k][ACC_W];
      acc_d[k] = sat_d[k] ? '1 : sum_d[k][ACC_W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      groups_q <= '0;
      base_q   <= '0;
      gcnt_q   <= '0;
      ecnt_q   <= '0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < 3; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          len_q    <= len;
          groups_q <= groups;
          base_q   <= base_addr;
          gcnt_q   <= '0;
          ecnt_q   <= '0;
          ovf_q    <= 1'b0;
          for (int k = 0; k < 3; k++) acc_q[k] <= '0;
          state_q  <= (len == 8'd0 || groups == 8'd0) ? DONE : ACCUM;
        end
        ACCUM: if (in_valid) begin
          for (int k = 0; k < 3; k++) acc_q[k] <= acc_d[k];
          ovf_q  <= ovf_q | (|sat_d);
          ecnt_q <= ecnt_q + 8'd1;
          if (ecnt_q == len_q - 8'd1) state_q <= WRITE;
        end
        WRITE: if (wr_ready) begin
          for (int k = 0; k < 3; k++) acc_q[k] <= '0;
          ecnt_q  <= '0;
          gcnt_q  <= gcnt_q + 8'd1;
          state_q <= (gcnt_q == groups_q - 8'd1) ? DONE : ACCUM;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == ACCUM;
  assign wr_en    = state_q == WRITE;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign ovf      = ovf_q;
  assign wr_addr  = base_q + ADDR_W'(gcnt_q);
  assign wr_data  = {acc_q[2], acc_q[1], acc_q[0]};
endmodule
